// File: rtl/ahb_lite_sram_responder.sv
`timescale 1ns/1ps
// ahb_lite_sram_responder
//   AHB-Lite subordinate backed by a word-addressed internal SRAM array.
//   The block supports byte, halfword and word transfers. It inserts a fixed
//   number of wait states (WAIT_STATES) before each OKAY data phase. Illegal
//   accesses receive the two-cycle ERROR response.
//
//   Optional feature: define AHB_SLV_ALIGN_CHK_EN to turn misaligned halfword
//   and word accesses into ERROR responses. When it is undefined, the low
//   address bits below the transfer size are ignored.
//
// Ports
//   HCLK       in   clock, rising edge
//   HRESET     in   synchronous active-high reset
//   HSEL       in   slave select
//   HADDR      in   byte address [ADDR_W]
//   HTRANS     in   IDLE=0 BUSY=1 NONSEQ=2 SEQ=3
//   HWRITE     in   1 = write
//   HSIZE      in   0 byte, 1 half, 2 word; larger sizes are errors
//   HBURST     in   ignored, every beat decoded on its own
//   HPROT      in   ignored
//   HWDATA     in   write data, valid in the data phase [DATA_W]
//   HREADY     in   bus-level ready
//   HREADYOUT  out  this slave's ready
//   HRESP      out  0 OKAY, 1 ERROR
//   HRDATA     out  read data, zero outside a read data cycle [DATA_W]
//
// FSM states
//   state  | meaning
//   IDLE   | no data phase in progress
//   WAIT   | OKAY data phase stalled, wait counter running
//   DATA   | final OKAY data cycle, write commits at its closing edge
//   ERR1   | first ERROR cycle (HREADYOUT low)
//   ERR2   | second ERROR cycle (HREADYOUT high)
module ahb_lite_sram_responder #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [3:0]        HPROT,
  input  logic [DATA_W-1:0] HWDATA,
  input  logic              HREADY,
  output logic              HREADYOUT,
  output logic              HRESP,
  output logic [DATA_W-1:0] HRDATA
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam int LANES = DATA_W / 8;
  localparam logic [ADDR_W:0] BYTE_LIMIT = (ADDR_W + 1)'(MEM_DEPTH * 4);
  // Counter is loaded with N-1 so that N WAIT cycles precede DATA.
  localparam logic [3:0] WS_INIT = 4'(WAIT_STATES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_DATA,
    S_ERR1,
    S_ERR2
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [IDX_W+1:0] addr_q;
  logic write_q;
  logic [1:0] size_q;

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic phase_ready;
  logic accept;
  logic range_err;
  logic size_err;
  logic align_err;
  logic req_err;
  logic [IDX_W-1:0] word_idx;
  logic [LANES-1:0] lane_en;

  logic unused_ok;
  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};

  // A new address phase can only be taken when this slave is not stalling
  // the bus. This guards against a master that ignores HREADYOUT.
  assign phase_ready = (state_q != S_WAIT) && (state_q != S_ERR1);
  assign accept      = HSEL && HREADY && HTRANS[1] && phase_ready;

  assign range_err = ({1'b0, HADDR} >= BYTE_LIMIT);
  assign size_err  = (HSIZE > 3'd2);
`ifdef AHB_SLV_ALIGN_CHK_EN
  assign align_err = ((HSIZE == 3'd1) && HADDR[0]) ||
                     ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif
  assign req_err = range_err || size_err || align_err;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE, S_DATA, S_ERR2: begin
        if (accept) begin
          if (req_err) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = WS_INIT;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        addr_q  <= HADDR[IDX_W+1:0];
        write_q <= HWRITE;
        size_q  <= HSIZE[1:0];
      end
    end
  end

  assign word_idx = addr_q[IDX_W+1:2];

  // Little-endian lane select. Halfwords ignore addr[0] and words ignore
  // addr[1:0]; misalignment has already been routed to ERR when enabled.
  always_comb begin
    lane_en = '0;
    unique case (size_q)
      2'd0:    lane_en[addr_q[1:0]] = 1'b1;
      2'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      default: lane_en = '1;
    endcase
  end

  // Errored transfers never reach DATA, so they cannot write. A DATA cycle
  // that overlaps reset is dropped.
  always_ff @(posedge HCLK) begin
    if (!HRESET && (state_q == S_DATA) && write_q) begin
      for (int i = 0; i < LANES; i++) begin
        if (lane_en[i]) begin
          mem[word_idx][8*i +: 8] <= HWDATA[8*i +: 8];
        end
      end
    end
  end

  assign HREADYOUT = phase_ready;
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
  // Combinational read lets a read immediately after a write see the new data.
  assign HRDATA    = ((state_q == S_DATA) && !write_q) ? mem[word_idx] : '0;

endmodule

// File: tb/tb_ahb_lite_sram_responder.sv
`timescale 1ns/1ps
module tb_ahb_lite_sram_responder;

  logic        clk;
  logic        rst;
  logic        sel0, sel1;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;
  logic        ready0, ready1;
  logic        resp0, resp1;
  logic [31:0] rdata0, rdata1;

  int n_checks = 0;
  int n_errors = 0;

  // dut0: no wait states, dut1: two wait states. Each sits alone on its bus,
  // so its HREADY is its own HREADYOUT.
  ahb_lite_sram_responder #(.WAIT_STATES(0)) dut0 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HWDATA(hwdata), .HREADY(ready0), .HREADYOUT(ready0), .HRESP(resp0),
    .HRDATA(rdata0)
  );

  ahb_lite_sram_responder #(.WAIT_STATES(2)) dut1 (
    .HCLK(clk), .HRESET(rst), .HSEL(sel1), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(hburst), .HPROT(hprot),
    .HWDATA(hwdata), .HREADY(ready1), .HREADYOUT(ready1), .HRESP(resp1),
    .HRDATA(rdata1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Single non-pipelined transfer to dut t. Returns the read data from the
  // completing cycle and the number of low-ready cycles. It also returns
  // HRESP from the first and last data-phase cycles.
  task automatic xfer(input int t, input logic wr, input logic [2:0] sz,
                      input logic [31:0] a, input logic [31:0] wd,
                      output logic [31:0] rd, output int lows,
                      output logic resp_first, output logic resp_last);
    logic rdy, rsp;
    int guard;
    @(posedge clk); #1;
    sel0 = (t == 0); sel1 = (t == 1);
    htrans = 2'd2; hwrite = wr; hsize = sz; haddr = a;
    @(posedge clk); #1;
    sel0 = 1'b0; sel1 = 1'b0; htrans = 2'd0; hwdata = wd;
    lows = 0; guard = 0;
    @(negedge clk);
    rdy = (t == 0) ? ready0 : ready1;
    rsp = (t == 0) ? resp0 : resp1;
    resp_first = rsp;
    while (!rdy && guard < 40) begin
      lows++; guard++;
      @(negedge clk);
      rdy = (t == 0) ? ready0 : ready1;
      rsp = (t == 0) ? resp0 : resp1;
    end
    if (!rdy) check("xfer_timeout", 32'd0, 32'd1);
    rd = (t == 0) ? rdata0 : rdata1;
    resp_last = rsp;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lows;
    logic rf, rl;
    logic exp_rdy;

    rst = 1'b1; sel0 = 1'b0; sel1 = 1'b0; haddr = '0; htrans = 2'd0;
    hwrite = 1'b0; hsize = 3'd2; hburst = 3'd0; hprot = 4'd0; hwdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready0", 32'(ready0), 32'd1);
    check("rst_resp0",  32'(resp0),  32'd0);
    check("rst_rdata0", rdata0,      32'd0);
    check("rst_ready1", 32'(ready1), 32'd1);
    check("rst_rdata1", rdata1,      32'd0);

    // WS=0: write then read back-to-back, no gap.
    @(posedge clk); #1;
    sel0 = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h10;
    @(posedge clk); #1;
    hwdata = 32'hDEADBEEF; hwrite = 1'b0;
    @(negedge clk);
    check("b2b_wr_ready", 32'(ready0), 32'd1);
    check("b2b_wr_resp",  32'(resp0),  32'd0);
    @(posedge clk); #1;
    sel0 = 1'b0; htrans = 2'd0;
    @(negedge clk);
    check("b2b_rd_ready", 32'(ready0), 32'd1);
    check("b2b_rd_resp",  32'(resp0),  32'd0);
    check("b2b_rd_data",  rdata0,      32'hDEADBEEF);

    // BUSY with select must not start a data phase.
    @(posedge clk); #1;
    sel0 = 1'b1; htrans = 2'd1; hwrite = 1'b0; haddr = 32'h10;
    @(posedge clk); #1;
    sel0 = 1'b0; htrans = 2'd0;
    @(negedge clk);
    check("busy_ready", 32'(ready0), 32'd1);
    check("busy_rdata", rdata0,      32'd0);

    // Byte lanes.
    xfer(0, 1'b1, 3'd2, 32'h20, 32'h11223344, rd, lows, rf, rl);
    xfer(0, 1'b1, 3'd0, 32'h22, 32'h55AA6677, rd, lows, rf, rl);
    xfer(0, 1'b1, 3'd1, 32'h20, 32'h9999BBCC, rd, lows, rf, rl);
    xfer(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, lows, rf, rl);
    check("lanes_data", rd, 32'h11AABBCC);
    check("lanes_lows", 32'(lows), 32'd0);

    // Out-of-range and oversize writes; 0x1000 aliases word 0 if undecoded.
    xfer(0, 1'b1, 3'd2, 32'h0, 32'hA5A5A5A5, rd, lows, rf, rl);
    xfer(0, 1'b1, 3'd2, 32'h1000, 32'hFFFFFFFF, rd, lows, rf, rl);
    check("range_lows",  32'(lows), 32'd1);
    check("range_resp1", 32'(rf),   32'd1);
    check("range_resp2", 32'(rl),   32'd1);
    xfer(0, 1'b1, 3'd3, 32'h0, 32'h00000000, rd, lows, rf, rl);
    check("size_lows",  32'(lows), 32'd1);
    check("size_resp1", 32'(rf),   32'd1);
    check("size_resp2", 32'(rl),   32'd1);
    xfer(0, 1'b0, 3'd2, 32'h0, 32'h0, rd, lows, rf, rl);
    check("err_nowrite", rd, 32'hA5A5A5A5);
    check("ok_resp", 32'(rl), 32'd0);

    // WS=2: single read, then back-to-back pipelined reads.
    xfer(1, 1'b1, 3'd2, 32'h100, 32'hCAFEF00D, rd, lows, rf, rl);
    xfer(1, 1'b1, 3'd2, 32'h104, 32'h12345678, rd, lows, rf, rl);
    xfer(1, 1'b0, 3'd2, 32'h104, 32'h0, rd, lows, rf, rl);
    check("ws2_lows", 32'(lows), 32'd2);
    check("ws2_data", rd, 32'h12345678);
    @(posedge clk); #1;
    sel1 = 1'b1; htrans = 2'd2; hwrite = 1'b0; hsize = 3'd2; haddr = 32'h100;
    @(posedge clk); #1;
    haddr = 32'h104;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      exp_rdy = (i == 3) || (i == 6);
      check($sformatf("pipe_ready_%0d", i), 32'(ready1), 32'(exp_rdy));
      if (i == 3) check("pipe_data_a", rdata1, 32'hCAFEF00D);
      if (i == 6) check("pipe_data_b", rdata1, 32'h12345678);
      @(posedge clk); #1;
      if (i == 3) begin
        sel1 = 1'b0; htrans = 2'd0;
      end
    end

    // Reset during WAIT of a write: nothing is committed.
    xfer(1, 1'b1, 3'd2, 32'h40, 32'h0, rd, lows, rf, rl);
    @(posedge clk); #1;
    sel1 = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h40;
    @(posedge clk); #1;
    sel1 = 1'b0; htrans = 2'd0; hwdata = 32'hFFFFFFFF; rst = 1'b1;
    @(negedge clk);
    check("rstw_wait_lo", 32'(ready1), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("rstw_ready", 32'(ready1), 32'd1);
    check("rstw_resp",  32'(resp1),  32'd0);
    xfer(1, 1'b0, 3'd2, 32'h40, 32'h0, rd, lows, rf, rl);
    check("rstw_mem", rd, 32'h0);

    // Reset coinciding with the DATA cycle of a write drops the write.
    xfer(0, 1'b1, 3'd2, 32'h44, 32'h13579BDF, rd, lows, rf, rl);
    @(posedge clk); #1;
    sel0 = 1'b1; htrans = 2'd2; hwrite = 1'b1; hsize = 3'd2; haddr = 32'h44;
    @(posedge clk); #1;
    sel0 = 1'b0; htrans = 2'd0; hwdata = 32'hFFFFFFFF; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    xfer(0, 1'b0, 3'd2, 32'h44, 32'h0, rd, lows, rf, rl);
    check("rstd_mem", rd, 32'h13579BDF);

    // Misaligned word read.
    xfer(0, 1'b1, 3'd2, 32'h40, 32'hCAFEBABE, rd, lows, rf, rl);
    xfer(0, 1'b0, 3'd2, 32'h42, 32'h0, rd, lows, rf, rl);
`ifdef AHB_SLV_ALIGN_CHK_EN
    check("align_lows",  32'(lows), 32'd1);
    check("align_resp1", 32'(rf),   32'd1);
    check("align_resp2", 32'(rl),   32'd1);
`else
    check("align_lows", 32'(lows), 32'd0);
    check("align_resp", 32'(rl),   32'd0);
    check("align_data", rd,        32'hCAFEBABE);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
